// File: rtl/tour_pkg.sv
// Shared types and constants for the tour script player.
//   state_e    : playback sequencer states
//   err_code_e : failure cause reported on err_code_o
//   OPC_W      : width of the opcode field at the top of each command
//   POS_ACK_DEFAULT / CAL_GYRO etc. : standard Knight bytes and commands
package tour_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [7:0]  POS_ACK_DEFAULT = 8'hA5;

    localparam logic [15:0] CAL_GYRO     = 16'h2000;
    localparam logic [15:0] MOVE_N1      = 16'h4001;
    localparam logic [15:0] MOVE_FANFARE = 16'h5BF1;
    localparam logic [15:0] TOUR_START   = 16'h6022;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_SNT,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_NAK   = 2'd1,
        ERR_TMO   = 2'd2,
        ERR_ABORT = 2'd3
    } err_code_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tmo_counter.sv
// Loadable down-counter used as a per-command watchdog.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : load load_val_i (has priority over counting)
//   en_i         : decrement while nonzero
//   expire_c_o   : combinational; high in the enabled cycle in which the count reaches 0
module tmo_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_c_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 becomes 0 on this edge; <= also catches a zero load
    assign expire_c_o = en_i && (cnt_q <= W'(1));

endmodule

// File: rtl/tour_script_player.sv
// Replays a stored script of Knight commands through RemoteComm, checking
// every response for positive acknowledge under a per-command timeout.
//   clk_i, rst_i            : clock, async active-high reset
//   wr_en_i/wr_data_i/clr_i : append to / empty the script (only while not playing)
//   start_i/abort_i         : begin playback from entry 0 / stop playback
//   snd_cmd_o/cmd_o         : command handshake towards RemoteComm
//   cmd_snt_i/resp_rdy_i/resp_i : RemoteComm progress and response byte
//   full_o/len_o            : script occupancy
//   busy_o/done_o/err_o     : playback status; err_code_o/err_idx_o give failure cause and entry
//   last_resp_o             : most recent response byte
module tour_script_player
    import tour_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CMD_W         = 16,
    parameter bit          FAST_SIM      = 1'b1,
    parameter int unsigned TMO_SHORT     = 32'd1 << 20,
    parameter int unsigned TMO_LONG      = 32'd1 << 28,
    parameter int unsigned TMO_SHORT_SIM = 32'd1 << 16,
    parameter int unsigned TMO_LONG_SIM  = 32'd1 << 24,
    parameter logic [15:0] LONG_OPC_MASK = 16'h00C0,
    parameter logic [7:0]  POS_ACK       = POS_ACK_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [CMD_W-1:0]           wr_data_i,
    input  logic                       clr_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       snd_cmd_o,
    output logic [CMD_W-1:0]           cmd_o,
    input  logic                       cmd_snt_i,
    input  logic                       resp_rdy_i,
    input  logic [7:0]                 resp_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     len_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic [$clog2(DEPTH)-1:0]   err_idx_o,
    output logic [7:0]                 last_resp_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = PTR_W + 1;
    localparam int unsigned TMO_S = FAST_SIM ? TMO_SHORT_SIM : TMO_SHORT;
    localparam int unsigned TMO_L = FAST_SIM ? TMO_LONG_SIM : TMO_LONG;
    localparam int unsigned TMO_W = $clog2(max_u(TMO_S, TMO_L) + 1);

    state_e               state_q, state_d;
    logic [CMD_W-1:0]     script_q [DEPTH];
    logic [LEN_W-1:0]     len_q, len_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic                 snd_cmd_q, snd_cmd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    err_code_e            err_code_q, err_code_d;
    logic [PTR_W-1:0]     err_idx_q, err_idx_d;
    logic [7:0]           last_resp_q, last_resp_d;
    logic                 full_q, full_d;
    logic                 wr_fire;
    logic                 fail;
    err_code_e            fail_code;
    logic [OPC_W-1:0]     opcode;
    logic [TMO_W-1:0]     tmo_val;
    logic                 tmo_expire;

    // Watchdog reload value chosen by the opcode of the command being issued
    assign opcode  = cmd_q[CMD_W-1 -: OPC_W];
    assign tmo_val = LONG_OPC_MASK[opcode] ? TMO_W'(TMO_L) : TMO_W'(TMO_S);

    tmo_counter #(.W(TMO_W)) u_tmo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (tmo_val),
        .en_i       ((state_q == ST_WAIT_SNT) || (state_q == ST_WAIT_RESP)),
        .expire_c_o (tmo_expire)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        cmd_d       = cmd_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_idx_d   = err_idx_q;
        last_resp_d = last_resp_q;
        wr_fire     = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (clr_i) begin
                    len_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_IDLE;
                end else if (wr_en_i && !full_q) begin
                    wr_fire = 1'b1;
                    len_d   = len_q + LEN_W'(1);
                end
                if (start_i) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    rd_ptr_d   = '0;
                    if (len_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        // Entry 0 may be the one being written this very cycle
                        cmd_d   = (wr_fire && (len_q == '0)) ? wr_data_i : script_q[0];
                    end
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    fail      = 1'b1;
                    fail_code = ERR_ABORT;
                end else begin
                    state_d = ST_WAIT_SNT;
                end
            end
            ST_WAIT_SNT, ST_WAIT_RESP: begin
                // Priority: abort, then response, then timeout, then cmd_snt
                if (abort_i) begin
                    fail      = 1'b1;
                    fail_code = ERR_ABORT;
                end else if (resp_rdy_i) begin
                    last_resp_d = resp_i;
                    if (resp_i != POS_ACK) begin
                        fail      = 1'b1;
                        fail_code = ERR_NAK;
                    end else if ((LEN_W'(rd_ptr_q) + LEN_W'(1)) == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        cmd_d    = script_q[rd_ptr_q + PTR_W'(1)];
                        state_d  = ST_ISSUE;
                    end
                end else if (tmo_expire) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end else if ((state_q == ST_WAIT_SNT) && cmd_snt_i) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = fail_code;
            err_idx_d  = rd_ptr_q;
        end

        snd_cmd_d = (state_d == ST_ISSUE);
        busy_d    = (state_d == ST_ISSUE) || (state_d == ST_WAIT_SNT) || (state_d == ST_WAIT_RESP);
        full_d    = (len_d == LEN_W'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            cmd_q       <= '0;
            snd_cmd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_idx_q   <= '0;
            last_resp_q <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_q       <= cmd_d;
            snd_cmd_q   <= snd_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_idx_q   <= err_idx_d;
            last_resp_q <= last_resp_d;
            full_q      <= full_d;
        end
    end

    // Script storage; emptied logically through len_q, so no reset needed
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            script_q[len_q[PTR_W-1:0]] <= wr_data_i;
        end
    end

    assign snd_cmd_o   = snd_cmd_q;
    assign cmd_o       = cmd_q;
    assign full_o      = full_q;
    assign len_o       = len_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign err_idx_o   = err_idx_q;
    assign last_resp_o = last_resp_q;

endmodule
